// File: rtl/lfsr_seq_ctrl.sv
// Fibonacci LFSR with load/start/stop control, all-zero lock-up detection and
// measurement of the number of steps needed to return to the start state.
module lfsr_seq_ctrl #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
    parameter logic [WIDTH-1:0] SEED_RST = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic             stop,
    input  logic             step_en,
    output logic [WIDTH-1:0] state,
    output logic             serial_out,
    output logic             running,
    output logic             lockup,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             period_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } fsm_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] start_ref_q, start_ref_d;
    logic [WIDTH-1:0] period_d;
    logic             period_valid_d;
    logic             period_ovf_d;
    logic             state_en;
    logic [WIDTH-1:0] state_d;
    logic             feedback;
    logic [WIDTH-1:0] state_nxt;

    assign feedback   = ^(state & TAPS);
    assign state_nxt  = {state[WIDTH-2:0], feedback};
    assign serial_out = state[WIDTH-1];

    // One enabled single-bit D cell per register bit; reset loads the matching SEED_RST bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic q;

        always_ff @(posedge clk) begin
            // NOTE: non-blocking assignments so every cell samples pre-edge values,
            // which is what makes the shift toward the MSB a true shift.
            if (reset) begin
                q <= SEED_RST[i];
            end else if (state_en) begin
                q <= state_d[i];
            end
        end

        assign state[i] = q;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        fsm_d          = fsm_q;
        cnt_d          = cnt_q;
        start_ref_d    = start_ref_q;
        period_d       = period;
        period_valid_d = period_valid;
        period_ovf_d   = period_ovf;
        state_en       = 1'b0;
        state_d        = state;

        if (load) begin
            state_en       = 1'b1;
            state_d        = seed;
            cnt_d          = '0;
            period_valid_d = 1'b0;
            period_ovf_d   = 1'b0;
            fsm_d          = (seed == '0) ? ST_LOCK : ST_IDLE;
        end else begin
            unique case (fsm_q)
                ST_IDLE: begin
                    if (stop) begin
                        fsm_d = ST_IDLE;
                    end else if (start) begin
                        if (state != '0) begin
                            fsm_d       = ST_RUN;
                            start_ref_d = state;
                            cnt_d       = '0;
                        end else begin
                            fsm_d = ST_LOCK;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        fsm_d = ST_IDLE;
                    end else if (step_en) begin
                        state_en = 1'b1;
                        state_d  = state_nxt;
                        cnt_d    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                        // Only the first recurrence is reported; a saturated counter
                        // without a recurrence means the start state is off the cycle.
                        if (!period_valid && state_nxt == start_ref_q) begin
                            period_d       = cnt_q + CNT_ONE;
                            period_valid_d = 1'b1;
                        end else if (!period_valid && cnt_q == CNT_MAX) begin
                            period_ovf_d = 1'b1;
                        end
                        if (state_nxt == '0) begin
                            fsm_d = ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    fsm_d = ST_LOCK;
                end
                default: begin
                    fsm_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= ST_IDLE;
            cnt_q        <= '0;
            start_ref_q  <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            period_ovf   <= 1'b0;
            running      <= 1'b0;
            lockup       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            cnt_q        <= cnt_d;
            start_ref_q  <= start_ref_d;
            period       <= period_d;
            period_valid <= period_valid_d;
            period_ovf   <= period_ovf_d;
            running      <= (fsm_d == ST_RUN);
            lockup       <= (fsm_d == ST_LOCK);
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Drives two LFSR instances (invertible and non-invertible taps) with shared
// directed then random stimulus and compares both against a behavioural model.
module tb_lfsr_seq_ctrl;

    localparam logic [3:0] TAPS_A = 4'b1100;
    localparam logic [3:0] TAPS_B = 4'b0110;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOCK = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, load, start, stop, step_en;
    logic [3:0] seed;

    logic [3:0] state_o  [2];
    logic       serial_o [2];
    logic       running_o[2];
    logic       lockup_o [2];
    logic [3:0] period_o [2];
    logic       pv_o     [2];
    logic       ovf_o    [2];

    lfsr_seq_ctrl #(.WIDTH(4), .TAPS(TAPS_A), .SEED_RST(4'b0001)) u_dut_a (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .start(start), .stop(stop),
        .step_en(step_en), .state(state_o[0]), .serial_out(serial_o[0]),
        .running(running_o[0]), .lockup(lockup_o[0]), .period(period_o[0]),
        .period_valid(pv_o[0]), .period_ovf(ovf_o[0])
    );

    lfsr_seq_ctrl #(.WIDTH(4), .TAPS(TAPS_B), .SEED_RST(4'b0001)) u_dut_b (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .start(start), .stop(stop),
        .step_en(step_en), .state(state_o[1]), .serial_out(serial_o[1]),
        .running(running_o[1]), .lockup(lockup_o[1]), .period(period_o[1]),
        .period_valid(pv_o[1]), .period_ovf(ovf_o[1])
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: one entry per instance.
    int         m_mode  [2];
    int         m_cnt   [2];
    logic [3:0] m_state [2];
    logic [3:0] m_ref   [2];
    logic [3:0] m_period[2];
    bit         m_pv    [2];
    bit         m_ovf   [2];
    bit         model_live = 0;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s, input logic [3:0] t);
        int shifted = (int'(s) * 2) % 16;
        int parity  = $countones(s & t) % 2;
        return 4'(shifted + parity);
    endfunction

    task automatic model_step(input int i, input logic [3:0] taps);
        logic [3:0] n;
        if (reset) begin
            m_mode[i] = M_IDLE; m_state[i] = 4'd1; m_cnt[i] = 0; m_ref[i] = 4'd0;
            m_period[i] = 4'd0; m_pv[i] = 0; m_ovf[i] = 0;
        end else if (load) begin
            m_state[i] = seed; m_cnt[i] = 0; m_pv[i] = 0; m_ovf[i] = 0;
            m_mode[i]  = (seed == 4'd0) ? M_LOCK : M_IDLE;
        end else if (m_mode[i] == M_IDLE) begin
            if (!stop && start) begin
                if (m_state[i] != 4'd0) begin
                    m_mode[i] = M_RUN; m_ref[i] = m_state[i]; m_cnt[i] = 0;
                end else begin
                    m_mode[i] = M_LOCK;
                end
            end
        end else if (m_mode[i] == M_RUN) begin
            if (stop) begin
                m_mode[i] = M_IDLE;
            end else if (step_en) begin
                n = lfsr_next(m_state[i], taps);
                if (!m_pv[i] && n == m_ref[i]) begin
                    m_period[i] = 4'(m_cnt[i] + 1);
                    m_pv[i]     = 1;
                end else if (!m_pv[i] && m_cnt[i] == 15) begin
                    m_ovf[i] = 1;
                end
                m_cnt[i]   = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
                m_state[i] = n;
                if (n == 4'd0) m_mode[i] = M_LOCK;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, TAPS_A);
        model_step(1, TAPS_B);
        if (reset) model_live = 1;
    end

    // Compare process: every output of both instances, every cycle, mid-cycle.
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                string p;
                p = (i == 0) ? "a" : "b";
                check({p, ".state"},   32'(state_o[i]),   32'(m_state[i]));
                check({p, ".serial"},  32'(serial_o[i]),  32'(m_state[i][3]));
                check({p, ".running"}, 32'(running_o[i]), 32'(m_mode[i] == M_RUN));
                check({p, ".lockup"},  32'(lockup_o[i]),  32'(m_mode[i] == M_LOCK));
                check({p, ".pv"},      32'(pv_o[i]),      32'(m_pv[i]));
                check({p, ".ovf"},     32'(ovf_o[i]),     32'(m_ovf[i]));
                if (m_pv[i] || m_period[i] == 4'd0)
                    check({p, ".period"}, 32'(period_o[i]), 32'(m_period[i]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] t2_seq [4];

    initial begin
        t2_seq[0] = 4'b0010; t2_seq[1] = 4'b0100; t2_seq[2] = 4'b1001; t2_seq[3] = 4'b0011;
        reset = 1; load = 0; seed = 0; start = 0; stop = 0; step_en = 0;
        cyc(); cyc();
        // T1
        check("t1.state",   32'(state_o[0]),   32'h1);
        check("t1.running", 32'(running_o[0]), 32'h0);
        check("t1.lockup",  32'(lockup_o[0]),  32'h0);
        check("t1.pv",      32'(pv_o[0]),      32'h0);
        check("t1.serial",  32'(serial_o[0]),  32'h0);
        check("t1.period",  32'(period_o[0]),  32'h0);
        reset = 0;

        // T2
        load = 1; seed = 4'b0001; cyc();
        load = 0; start = 1; step_en = 1; cyc();
        start = 0;
        check("t2.running", 32'(running_o[0]), 32'h1);
        check("t2.no_step_yet", 32'(state_o[0]), 32'h1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("t2.step%0d", k + 1), 32'(state_o[0]), 32'(t2_seq[k]));
        end
        for (int k = 5; k < 15; k++) cyc();
        check("t2.pv_before", 32'(pv_o[0]), 32'h0);
        cyc();
        check("t2.state15", 32'(state_o[0]),  32'h1);
        check("t2.pv",      32'(pv_o[0]),     32'h1);
        check("t2.period",  32'(period_o[0]), 32'd15);
        check("t2.model_period", 32'(m_period[0]), 32'd15);
        stop = 1; cyc(); stop = 0;
        check("t2.stopped", 32'(running_o[0]), 32'h0);
        check("t2.pv_kept", 32'(pv_o[0]),      32'h1);

        // T3
        load = 1; seed = 4'b0000; cyc(); load = 0;
        check("t3.lockup", 32'(lockup_o[0]), 32'h1);
        check("t3.state0", 32'(state_o[0]),  32'h0);
        start = 1; cyc(); start = 0;
        check("t3.start_ignored", 32'(running_o[0]), 32'h0);
        check("t3.still_locked",  32'(lockup_o[0]),  32'h1);
        load = 1; seed = 4'b1010; cyc(); load = 0;
        check("t3.unlocked",  32'(lockup_o[0]), 32'h0);
        check("t3.state",     32'(state_o[0]),  32'hA);
        check("t3.pv_clear",  32'(pv_o[0]),     32'h0);

        // T5
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        check("t5.running", 32'(running_o[0]), 32'h0);
        check("t5.state",   32'(state_o[0]),   32'hA);

        // T4
        start = 1; step_en = 1; cyc(); start = 0;
        for (int k = 0; k < 30; k++) begin
            step_en = (k % 2 == 0);
            cyc();
            if (k < 2) check($sformatf("t4.gate%0d", k), 32'(state_o[0]), 32'h5);
        end
        check("t4.state",  32'(state_o[0]),  32'hA);
        check("t4.pv",     32'(pv_o[0]),     32'h1);
        check("t4.period", 32'(period_o[0]), 32'd15);
        stop = 1; step_en = 1; cyc(); stop = 0;

        // T6
        load = 1; seed = 4'b0001; cyc(); load = 0;
        start = 1; cyc(); start = 0;
        repeat (20) cyc();
        check("t6.b_ovf",     32'(ovf_o[1]),     32'h1);
        check("t6.b_pv",      32'(pv_o[1]),      32'h0);
        check("t6.b_running", 32'(running_o[1]), 32'h1);
        check("t6.a_ovf",     32'(ovf_o[0]),     32'h0);
        check("t6.a_period",  32'(period_o[0]),  32'd15);
        reset = 1; cyc(); reset = 0;
        check("t6.rst_state",   32'(state_o[1]),   32'h1);
        check("t6.rst_ovf",     32'(ovf_o[1]),     32'h0);
        check("t6.rst_running", 32'(running_o[1]), 32'h0);
        check("t6.rst_period",  32'(period_o[0]),  32'h0);
        check("t6.rst_pv",      32'(pv_o[0]),      32'h0);

        // Random phase, checked by the compare process against the model.
        repeat (2000) begin
            reset   = ($urandom % 200) == 0;
            load    = ($urandom % 16) == 0;
            seed    = 4'($urandom);
            start   = ($urandom % 8) == 0;
            stop    = ($urandom % 24) == 0;
            step_en = ($urandom % 4) != 0;
            cyc();
        end
        reset = 0; load = 0; start = 0; stop = 0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
